// File: rtl/ascii_pkg.sv
// Shared constants and types for the luminance-to-ASCII path.
// Holds the default glyph ramp, control-character codes, EOL mode encodings
// and the end-of-line FSM state type.
package ascii_pkg;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int EOL_NONE = 0;
    localparam int EOL_LF   = 1;
    localparam int EOL_CRLF = 2;

    localparam int RAMP_DEPTH = 64;

    // Dark-to-bright glyph ramp, entries 0..47 (index 0 is space).
    // Entries 48..63 are spaces.
    localparam logic [0:RAMP_DEPTH-1][7:0] DEFAULT_RAMP = '{
        8'h20, 8'h2E, 8'h60, 8'h2D, 8'h2C, 8'h3A, 8'h3B, 8'h7E,
        8'h2B, 8'h2F, 8'h3D, 8'h3E, 8'h7C, 8'h28, 8'h29, 8'h5C,
        8'h69, 8'h25, 8'h7B, 8'h2A, 8'h73, 8'h76, 8'h37, 8'h61,
        8'h65, 8'h43, 8'h4A, 8'h4C, 8'h54, 8'h59, 8'h77, 8'h46,
        8'h39, 8'h56, 8'h47, 8'h58, 8'h41, 8'h45, 8'h24, 8'h26,
        8'h23, 8'h40, 8'h52, 8'h57, 8'h30, 8'h4E, 8'h4D, 8'h51,
        8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
        8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20
    };

    typedef enum logic [1:0] {
        EOL_ST_DATA = 2'd0,
        EOL_ST_CR   = 2'd1,
        EOL_ST_LF   = 2'd2
    } eol_state_t;

    // Reset value for table slot idx; slots past the built-in ramp are spaces.
    function automatic logic [7:0] ramp_default(input int idx);
        logic [7:0] val;
        val = ASCII_SP;
        if (idx >= 0 && idx < RAMP_DEPTH) begin
            val = DEFAULT_RAMP[idx[5:0]];
        end
        return val;
    endfunction

endpackage

// File: rtl/ascii_ramp_table.sv
// Writable glyph table: LEVELS x 8 register file, async reset to the default ramp.
// Latency: registered read, data valid the cycle after rd_en_i; held while rd_en_i=0.
// Backpressure: none internally; the caller stalls by withholding rd_en_i.
// Ports: clk/rst_n; wr_en_i/wr_addr_i/wr_data_i write port (out-of-range ignored);
//        rd_en_i/rd_addr_i read request; rd_data_o registered read data (resets to space).
module ascii_ramp_table
    import ascii_pkg::*;
#(
    parameter int ID_W   = 6,
    parameter int LEVELS = 48
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en_i,
    input  logic [ID_W-1:0] wr_addr_i,
    input  logic [7:0]      wr_data_i,
    input  logic            rd_en_i,
    input  logic [ID_W-1:0] rd_addr_i,
    output logic [7:0]      rd_data_o
);

    logic [7:0] mem_q [LEVELS];
    logic [7:0] rd_data_q;
    logic       wr_hit;

    // Extra bit so LEVELS == 2^ID_W compares correctly.
    assign wr_hit = wr_en_i && ({1'b0, wr_addr_i} < (ID_W+1)'(LEVELS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEVELS; i++) begin
                mem_q[i] <= ramp_default(i);
            end
        end else if (wr_hit) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read samples the pre-write array, so a same-cycle write to the same
    // slot is seen only by later lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= ASCII_SP;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ascii_ramp_mapper.sv
// Streaming luminance-to-ASCII mapper: scale -> ramp lookup -> optional CR/LF insertion.
// Latency: two register stages; output valid two edges after the accepting cycle begins.
// Backpressure: full valid/ready; in_ready is combinational from out_ready, no stall bubbles.
// Ports: in_valid/in_ready/in_lum/in_last/invert sample input; cfg_we/cfg_addr/cfg_data
//        ramp table write; out_valid/out_ready/out_char/out_last character output.
module ascii_ramp_mapper
    import ascii_pkg::*;
#(
    parameter int LUM_W    = 8,
    parameter int ID_W     = 6,
    parameter int LEVELS   = 48,
    parameter int EOL_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LUM_W-1:0] in_lum,
    input  logic             in_last,
    input  logic             invert,
    input  logic             cfg_we,
    input  logic [ID_W-1:0]  cfg_addr,
    input  logic [7:0]       cfg_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last
);

    localparam int PW = LUM_W + ID_W + 1;

    // ---------------- stage 1: scale ----------------
    logic [LUM_W-1:0] lum_eff;
    logic [PW-1:0]    prod;
    logic [ID_W-1:0]  id_d;

    logic             s1_vld_q;
    logic [ID_W-1:0]  s1_id_q;
    logic             s1_last_q;

    // ---------------- stage 2: lookup ----------------
    logic             s2_vld_q;
    logic             s2_last_q;
    logic [7:0]       tbl_char;

    // ---------------- flow control / EOL ----------------
    eol_state_t       st_q;
    eol_state_t       st_d;
    logic             s2_ld;
    logic             s1_adv;
    logic             in_fire;
    logic             data_fire;

    // Inverting an unsigned sample is (2^LUM_W-1) - lum, i.e. bitwise NOT.
    assign lum_eff = invert ? ~in_lum : in_lum;
    // floor(lum * LEVELS / 2^LUM_W) always lands in 0..LEVELS-1.
    assign prod    = PW'(lum_eff) * PW'(LEVELS);
    assign id_d    = ID_W'(prod >> LUM_W);

    // Stage 2 may only take new data while the FSM is passing characters;
    // during CR/LF it holds the next character in place.
    assign s2_ld     = (st_q == EOL_ST_DATA) && (!s2_vld_q || out_ready);
    assign s1_adv    = s1_vld_q && s2_ld;
    assign in_ready  = !s1_vld_q || s1_adv;
    assign in_fire   = in_valid && in_ready;
    assign data_fire = (st_q == EOL_ST_DATA) && s2_vld_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_id_q   <= '0;
            s1_last_q <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_vld_q <= in_valid;
            end
            if (in_fire) begin
                s1_id_q   <= id_d;
                s1_last_q <= in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
        end else begin
            if (s2_ld) begin
                s2_vld_q <= s1_vld_q;
            end
            if (s1_adv) begin
                s2_last_q <= s1_last_q;
            end
        end
    end

    // The table's read register is the stage-2 character; reading only on
    // s1_adv keeps a stalled character frozen regardless of table writes.
    ascii_ramp_table #(
        .ID_W   (ID_W),
        .LEVELS (LEVELS)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (cfg_we),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_en_i   (s1_adv),
        .rd_addr_i (s1_id_q),
        .rd_data_o (tbl_char)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= EOL_ST_DATA;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        out_valid = s2_vld_q;
        out_char  = tbl_char;
        // With EOL insertion the LF, not the data character, closes the row.
        out_last  = (EOL_MODE == EOL_NONE) && s2_last_q;
        case (st_q)
            EOL_ST_DATA: begin
                if (data_fire && s2_last_q) begin
                    if (EOL_MODE == EOL_CRLF) begin
                        st_d = EOL_ST_CR;
                    end else if (EOL_MODE == EOL_LF) begin
                        st_d = EOL_ST_LF;
                    end
                end
            end
            EOL_ST_CR: begin
                out_valid = 1'b1;
                out_char  = ASCII_CR;
                out_last  = 1'b0;
                if (out_ready) begin
                    st_d = EOL_ST_LF;
                end
            end
            EOL_ST_LF: begin
                out_valid = 1'b1;
                out_char  = ASCII_LF;
                out_last  = 1'b1;
                if (out_ready) begin
                    st_d = EOL_ST_DATA;
                end
            end
            default: begin
                st_d = EOL_ST_DATA;
            end
        endcase
    end

endmodule
